// File: rtl/dmem_arb_if.sv
`default_nettype none
//-----------------------------------------------------------------------------
// Module      : dmem_arb_if
// Description : Requester-side bus of the data-memory arbiter. Carries the
//               flattened per-requester request, write, address and data
//               vectors, plus the grant and read-response vectors.
// Revision    : 1.0 - initial release
//-----------------------------------------------------------------------------
`ifndef DATA_W
`define DATA_W 16
`endif

interface dmem_arb_if #(
   parameter int NREQ = 4,
   parameter int AW   = 16,
   parameter int DW   = `DATA_W
);
   logic [NREQ-1:0]    req;
   logic [NREQ-1:0]    we;
   logic [NREQ*AW-1:0] addr;
   logic [NREQ*DW-1:0] wdata;
   logic [NREQ-1:0]    gnt;
   logic [NREQ-1:0]    rvalid;
   logic [NREQ*DW-1:0] rdata;

   // Requester view: drives requests, receives grants and read data.
   modport master (
      output req, we, addr, wdata,
      input  gnt, rvalid, rdata
   );

   // Arbiter view.
   modport slave (
      input  req, we, addr, wdata,
      output gnt, rvalid, rdata
   );
endinterface

`default_nettype wire

// File: rtl/dmem_arb.sv
`default_nettype none
//-----------------------------------------------------------------------------
// Module      : dmem_arb
// Description : Round-robin arbiter sharing the two ports (A, B) of a
//               dual-port data memory among NREQ requesters. Up to two
//               requests are accepted per cycle; first winner drives port A,
//               second drives port B. Read data returns one cycle later.
// Revision    : 1.0 - initial release
//-----------------------------------------------------------------------------
`ifndef DATA_W
`define DATA_W 16
`endif

module dmem_arb #(
   parameter int NREQ = 4,
   parameter int AW   = 16,
   parameter int DW   = `DATA_W
) (
   input  logic          clk,
   input  logic          rst,
   dmem_arb_if.slave     bus,
   output logic [AW-1:0] a_a_o,
   output logic [AW-1:0] a_b_o,
   output logic [DW-1:0] wd_a_o,
   output logic [DW-1:0] wd_b_o,
   output logic          we_a_o,
   output logic          we_b_o,
   input  logic [DW-1:0] rd_a_i,
   input  logic [DW-1:0] rd_b_i
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   // Round-robin pointer: index of the highest-priority requester.
   logic [PW-1:0]   ptr_q;
   logic [PW-1:0]   ptr_d;

   // Winners of the current cycle.
   logic            w0_vld;
   logic [PW-1:0]   w0_idx;
   logic            w1_vld;
   logic [PW-1:0]   w1_idx;
   logic [PW-1:0]   last_idx;

   // One-hot grant per port.
   logic [NREQ-1:0] gnt_a;
   logic [NREQ-1:0] gnt_b;

   // Scan from ptr upwards (wrapping) and pick up to two winners. A second
   // write to the same address as a write winner is skipped so both ports
   // never write one location in the same cycle. Reset blocks every grant.
   always_comb begin : p_scan
      logic [PW-1:0] cand;
      cand   = '0;
      w0_vld = 1'b0;
      w0_idx = '0;
      w1_vld = 1'b0;
      w1_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = PW'((int'(ptr_q) + k) % NREQ);
         if (!rst && bus.req[cand]) begin
            if (!w0_vld) begin
               w0_vld = 1'b1;
               w0_idx = cand;
            end else if (!w1_vld &&
                         !(bus.we[w0_idx] && bus.we[cand] &&
                           (bus.addr[w0_idx*AW +: AW] == bus.addr[cand*AW +: AW]))) begin
               w1_vld = 1'b1;
               w1_idx = cand;
            end
         end
      end
   end

   // Decode the winners into per-port one-hot grant vectors.
   always_comb begin
      gnt_a = '0;
      gnt_b = '0;
      if (w0_vld) begin
         gnt_a[w0_idx] = 1'b1;
      end
      if (w1_vld) begin
         gnt_b[w1_idx] = 1'b1;
      end
   end

   assign bus.gnt = gnt_a | gnt_b;

   // Memory port A follows W0; an idle port drives all zeros.
   always_comb begin
      a_a_o  = '0;
      wd_a_o = '0;
      we_a_o = 1'b0;
      if (w0_vld) begin
         a_a_o  = bus.addr[w0_idx*AW +: AW];
         wd_a_o = bus.wdata[w0_idx*DW +: DW];
         we_a_o = bus.we[w0_idx];
      end
   end

   // Memory port B follows W1; an idle port drives all zeros.
   always_comb begin
      a_b_o  = '0;
      wd_b_o = '0;
      we_b_o = 1'b0;
      if (w1_vld) begin
         a_b_o  = bus.addr[w1_idx*AW +: AW];
         wd_b_o = bus.wdata[w1_idx*DW +: DW];
         we_b_o = bus.we[w1_idx];
      end
   end

   // Next pointer: one past the last winner, or unchanged when idle. A
   // requester skipped between the winners ends up behind the new pointer.
   always_comb begin
      last_idx = w1_vld ? w1_idx : w0_idx;
      ptr_d    = ptr_q;
      if (w0_vld) begin
         ptr_d = PW'((int'(last_idx) + 1) % NREQ);
      end
   end

   // Pointer register.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   // Per-requester read response: capture the serving port's data at the
   // edge that ends a granted read; hold rdata otherwise.
   for (genvar i = 0; i < NREQ; i++) begin : g_resp
      logic          rvalid_q;
      logic          rvalid_d;
      logic [DW-1:0] rdata_q;
      logic [DW-1:0] rdata_d;

      // Select the returned word from whichever port served this requester.
      always_comb begin
         rvalid_d = (gnt_a[i] | gnt_b[i]) & ~bus.we[i];
         rdata_d  = rdata_q;
         if (gnt_a[i] && !bus.we[i]) begin
            rdata_d = rd_a_i;
         end else if (gnt_b[i] && !bus.we[i]) begin
            rdata_d = rd_b_i;
         end
      end

      // Response registers; reset discards any read granted in that cycle.
      always_ff @(posedge clk) begin
         if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
         end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
         end
      end

      assign bus.rvalid[i]           = rvalid_q;
      assign bus.rdata[i*DW +: DW]   = rdata_q;
   end

   // Structural invariants of the grant vector.
   a_no_gnt_in_rst : assert property (@(posedge clk) rst |-> (bus.gnt == '0));
   a_max_two_gnt   : assert property (@(posedge clk) $countones(bus.gnt) <= 2);
   a_gnt_needs_req : assert property (@(posedge clk) (bus.gnt & ~bus.req) == '0);

endmodule

`default_nettype wire
